// File: rtl/sram_ctrl.sv
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Splits a 32-bit LSU access into low/high half-word phases on a
//            16-bit asynchronous SRAM.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_ctrl #(
  parameter int ACC_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_st_strb,
  input  logic        i_lsu_wren,
  output logic [31:0] o_ld_data,
  output logic        o_busy,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] c_last = 4'(ACC_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [16:0] r_word, w_word_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [3:0]  r_strb, w_strb_nxt;
  logic        r_wren, w_wren_nxt;

  logic [31:0] r_ld;
  logic [17:0] r_sram_addr;
  logic [15:0] r_dq_out;
  logic        r_dq_oe;
  logic        r_ce_n, r_we_n, r_oe_n, r_lb_n, r_ub_n;

  logic        w_last;
  logic        w_phase;
  logic        w_half;
  logic [1:0]  w_half_strb;
  logic [15:0] w_half_data;
  logic        w_unused_addr;

  assign w_last        = (r_cnt == c_last);
  assign w_unused_addr = ^{i_lsu_addr[31:19], i_lsu_addr[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_data_nxt  = r_data;
    w_strb_nxt  = r_strb;
    w_wren_nxt  = r_wren;
    case (r_state)
      S_IDLE: begin
        if (i_VALID) begin
          w_word_nxt = i_lsu_addr[18:2];
          w_data_nxt = i_st_data;
          w_strb_nxt = i_st_strb;
          w_wren_nxt = i_lsu_wren;
          w_cnt_nxt  = '0;
          if (!i_lsu_wren || (|i_st_strb[1:0])) begin
            w_state_nxt = S_LO;
          end else if (|i_st_strb[3:2]) begin
            w_state_nxt = S_HI;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LO: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (!r_wren || (|r_strb[3:2])) ? S_HI : S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_HI: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin outputs are registered from the upcoming state so they are glitch-free
  // and stable for the whole phase.
  assign w_phase     = (w_state_nxt == S_LO) || (w_state_nxt == S_HI);
  assign w_half      = (w_state_nxt == S_HI);
  assign w_half_strb = w_half ? w_strb_nxt[3:2] : w_strb_nxt[1:0];
  assign w_half_data = w_half ? w_data_nxt[31:16] : w_data_nxt[15:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_data      <= '0;
      r_strb      <= '0;
      r_wren      <= 1'b0;
      r_ld        <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_ub_n      <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_data  <= w_data_nxt;
      r_strb  <= w_strb_nxt;
      r_wren  <= w_wren_nxt;

      r_ce_n  <= !w_phase;
      r_oe_n  <= !(w_phase && !w_wren_nxt);
      // WE_N rises on the last phase cycle so data is held past the write.
      r_we_n  <= !(w_phase && w_wren_nxt && (w_cnt_nxt != c_last));
      r_lb_n  <= !(w_phase && (!w_wren_nxt || w_half_strb[0]));
      r_ub_n  <= !(w_phase && (!w_wren_nxt || w_half_strb[1]));
      r_dq_oe <= w_phase && w_wren_nxt;
      if (w_phase) begin
        r_sram_addr <= {w_word_nxt, w_half};
        r_dq_out    <= w_half_data;
      end

      if ((r_state == S_LO) && !r_wren && w_last) begin
        r_ld[15:0] <= SRAM_DQ;
      end
      if ((r_state == S_HI) && !r_wren && w_last) begin
        r_ld[31:16] <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {16{1'bz}};
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_LB_N = r_lb_n;
  assign SRAM_UB_N = r_ub_n;
  assign o_ld_data = r_ld;
  assign o_READY   = (r_state == S_DONE);
  assign o_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl.sv
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Self-checking bench for sram_ctrl (ACC_CYC=2 and ACC_CYC=4).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid2, valid4;
  logic [31:0] lsu_addr, st_data;
  logic [3:0]  strb;
  logic        wren;

  wire         ready2, busy2, ce2, we2, oe2, lb2, ub2;
  wire  [31:0] ld2;
  wire  [17:0] sa2;
  wire  [15:0] dq2;
  wire         ready4, busy4, ce4, we4, oe4, lb4, ub4;
  wire  [31:0] ld4;
  wire  [17:0] sa4;
  wire  [15:0] dq4;

  sram_ctrl #(.ACC_CYC(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_VALID(valid2), .o_READY(ready2),
    .i_lsu_addr(lsu_addr), .i_st_data(st_data), .i_st_strb(strb), .i_lsu_wren(wren),
    .o_ld_data(ld2), .o_busy(busy2), .SRAM_ADDR(sa2), .SRAM_DQ(dq2),
    .SRAM_CE_N(ce2), .SRAM_WE_N(we2), .SRAM_OE_N(oe2), .SRAM_LB_N(lb2), .SRAM_UB_N(ub2)
  );

  sram_ctrl #(.ACC_CYC(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_VALID(valid4), .o_READY(ready4),
    .i_lsu_addr(lsu_addr), .i_st_data(st_data), .i_st_strb(strb), .i_lsu_wren(wren),
    .o_ld_data(ld4), .o_busy(busy4), .SRAM_ADDR(sa4), .SRAM_DQ(dq4),
    .SRAM_CE_N(ce4), .SRAM_WE_N(we4), .SRAM_OE_N(oe4), .SRAM_LB_N(lb4), .SRAM_UB_N(ub4)
  );

  // Asynchronous SRAM pin models: drive on read, capture writes mid-cycle.
  logic [15:0] mem2 [0:262143];
  logic [15:0] mem4 [0:262143];
  assign dq2 = (!ce2 && !oe2 && we2) ? mem2[sa2] : 16'hzzzz;
  assign dq4 = (!ce4 && !oe4 && we4) ? mem4[sa4] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem2[i] = 16'h0000;
      mem4[i] = 16'h0000;
    end
    forever begin
      @(negedge clk);
      if (!ce2 && !we2) begin
        if (!lb2) mem2[sa2][7:0]  = dq2[7:0];
        if (!ub2) mem2[sa2][15:8] = dq2[15:8];
      end
      if (!ce4 && !we4) begin
        if (!lb4) mem4[sa4][7:0]  = dq4[7:0];
        if (!ub4) mem4[sa4][15:8] = dq4[15:8];
      end
    end
  end

  logic        sel;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [int];
  logic [31:0] exp_ld [2];

  function automatic logic m_ready();        return sel ? ready4 : ready2; endfunction
  function automatic logic m_busy();         return sel ? busy4 : busy2;   endfunction
  function automatic logic [31:0] m_ld();    return sel ? ld4 : ld2;       endfunction
  function automatic logic [17:0] m_addr();  return sel ? sa4 : sa2;       endfunction
  function automatic logic [15:0] m_dq();    return sel ? dq4 : dq2;       endfunction
  function automatic logic [4:0] m_ctrl();
    return sel ? {ce4, we4, oe4, lb4, ub4} : {ce2, we2, oe2, lb2, ub2};
  endfunction

  function automatic int ref_key(bit inst, logic [16:0] word, int b);
    return (int'(inst) << 20) | (int'(word) << 2) | b;
  endfunction

  function automatic logic [31:0] ref_word(bit inst, logic [16:0] word);
    logic [31:0] r;
    int          k;
    for (int b = 0; b < 4; b++) begin
      k = ref_key(inst, word, b);
      r[8*b +: 8] = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input bit inst, input string tag);
    sel = inst;
    chk({tag, "_ready_busy"}, {m_ready(), m_busy()}, 2'b00);
    chk({tag, "_ctrl"}, m_ctrl(), 5'b11111);
    chk({tag, "_dq"}, m_dq(), 16'hzzzz);
  endtask

  // Called at #1 after a rising edge with the controller idle; that cycle is A.
  task automatic access(input bit inst, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit w, input bit hold,
                        input logic [31:0] next_a);
    int          acc, lat, p, j, h;
    int          halves[$];
    logic [16:0] word;
    logic [1:0]  hs;
    logic [31:0] refw;
    acc  = inst ? 4 : 2;
    word = a[18:2];
    refw = ref_word(inst, word);
    if (!w) halves = '{0, 1};
    else begin
      if (|s[1:0]) halves.push_back(0);
      if (|s[3:2]) halves.push_back(1);
    end
    lat = 1 + acc * halves.size();
    sel = inst;
    lsu_addr = a; st_data = d; strb = s; wren = w;
    if (inst) valid4 = 1'b1; else valid2 = 1'b1;
    chk("accept_busy", m_busy(), 1'b0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (!hold) begin valid2 = 1'b0; valid4 = 1'b0; end
      if (hold && k == 2) lsu_addr = next_a;
      chk("ready", m_ready(), (k == lat));
      chk("busy", m_busy(), 1'b1);
      if (k < lat) begin
        p  = (k - 1) / acc;
        j  = (k - 1) % acc;
        h  = halves[p];
        hs = (h == 1) ? s[3:2] : s[1:0];
        chk("ctrl", m_ctrl(), {1'b0, (w ? (j == acc - 1) : 1'b1), w,
                               (w ? ~hs[0] : 1'b0), (w ? ~hs[1] : 1'b0)});
        chk("addr", m_addr(), {word, (h == 1)});
        if (w) chk("dq_wr", m_dq(), (h == 1) ? d[31:16] : d[15:0]);
        else   chk("dq_rd", m_dq(), (h == 1) ? refw[31:16] : refw[15:0]);
      end else begin
        chk("done_ctrl", m_ctrl(), 5'b11111);
        chk("done_dq", m_dq(), 16'hzzzz);
      end
    end
    if (!w) exp_ld[inst] = refw;
    chk("ld_data", m_ld(), exp_ld[inst]);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[ref_key(inst, word, b)] = d[8*b +: 8];
      end
    end
    @(posedge clk); #1;
    chk_quiet(inst, "after_done");
  endtask

  initial begin
    logic [31:0] ra;
    rst_n = 1'b0; valid2 = 1'b0; valid4 = 1'b0;
    lsu_addr = '0; st_data = '0; strb = '0; wren = 1'b0; sel = 1'b0;
    exp_ld[0] = '0; exp_ld[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_quiet(i[0], "reset");
      chk("reset_addr", m_addr(), 18'h0);
      chk("reset_ld", m_ld(), 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read back, fast part.
    access(0, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 1, 0, 0);
    access(0, 32'h0000_0010, 32'h0, 4'b0000, 0, 0, 0);
    // Upper-byte-only write merges with existing contents.
    access(0, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1, 0, 0);
    access(0, 32'h0000_0020, 32'hAA00_0000, 4'b1000, 1, 0, 0);
    access(0, 32'h0000_0020, 32'h0, 4'b0000, 0, 0, 0);
    access(0, 32'h0000_0030, 32'h1234_5678, 4'b0000, 1, 0, 0);
    // Highest word on the slow part.
    access(1, 32'h0007_FFFC, 32'hCAFE_F00D, 4'b1111, 1, 0, 0);
    access(1, 32'h0007_FFFC, 32'h0, 4'b0000, 0, 0, 0);
    // Back-to-back reads with VALID held and address changed mid-access.
    access(0, 32'h0000_0010, 32'h0, 4'b0000, 0, 1, 32'h0000_0020);
    access(0, 32'h0000_0020, 32'h0, 4'b0000, 0, 0, 0);

    // Reset in the middle of a low-half write.
    sel = 1'b0;
    lsu_addr = 32'h0000_0040; st_data = 32'h5555_6666; strb = 4'b1111; wren = 1'b1;
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    chk("abort_pre_ctrl", m_ctrl(), 5'b00100);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet(0, "abort");
    chk("abort_ld", m_ld(), 32'h0);
    exp_ld[0] = '0; exp_ld[1] = '0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk_quiet(0, "post_abort");
    end

    // Randomized accesses over a small word pool on both parts.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      ra[18:2] = 17'($urandom_range(0, 7));
      access(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
